// File: rtl/bcd_pkg.sv
// Shared constants for the BCD display path: segment patterns {g,f,e,d,c,b,a}
// (active-high), the scan digit states and the largest legal BCD digit.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX   = 4'd9;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic {
        DIG_ONES = 1'b0,
        DIG_TENS = 1'b1
    } digit_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational nibble to 7-segment decoder (active-high). force_dash wins over
// everything, then any non-BCD nibble renders as "E".
module bcd_to_seg7
    import bcd_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       force_dash,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        if (force_dash) begin
            pattern = SEG_DASH;
        end else if (nibble > BCD_MAX) begin
            pattern = SEG_E;
        end else begin
            case (nibble)
                4'd0:    pattern = SEG_0;
                4'd1:    pattern = SEG_1;
                4'd2:    pattern = SEG_2;
                4'd3:    pattern = SEG_3;
                4'd4:    pattern = SEG_4;
                4'd5:    pattern = SEG_5;
                4'd6:    pattern = SEG_6;
                4'd7:    pattern = SEG_7;
                4'd8:    pattern = SEG_8;
                4'd9:    pattern = SEG_9;
                default: pattern = SEG_E;
            endcase
        end
    end

endmodule

// File: rtl/bcd_sum_display.sv
// Captures a 2-digit BCD sum and scans it onto a multiplexed 7-segment display.
// Optional macro BCD_DISP_LZ_BLANK_EN blanks a leading-zero tens digit.
//
// state    | meaning
// DIG_ONES | ones digit (sum_q[3:0]) is being driven
// DIG_TENS | tens digit (sum_q[7:4]) is being driven
module bcd_sum_display
    import bcd_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sum_valid,
    input  logic [7:0] sum_in,
    input  logic       in_err,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       err
);

    localparam int             CW      = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  CNT_TC  = CW'(REFRESH_DIV - 1);
    localparam logic [6:0]     SEG_POL = {7{SEG_ACTIVE_LOW}};
    localparam logic [1:0]     AN_POL  = {2{SEG_ACTIVE_LOW}};

    logic [7:0]    sum_q;
    logic          err_q;
    logic [CW-1:0] cnt;
    logic          tc;
    digit_t        state, state_nxt;
    logic [3:0]    nib;
    logic [6:0]    pattern, seg_nxt;
    logic [1:0]    an_nxt;
    logic          err_nxt;

    assign tc = (cnt == CNT_TC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= 8'h00;
            err_q <= 1'b0;
            cnt   <= '0;
            state <= DIG_ONES;
        end else begin
            if (sum_valid) begin
                sum_q <= sum_in;
                err_q <= in_err;
            end
            cnt   <= tc ? '0 : cnt + CW'(1);
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        nib       = sum_q[3:0];
        an_nxt    = 2'b01;
        case (state)
            DIG_ONES: begin
                if (tc) state_nxt = DIG_TENS;
            end
            DIG_TENS: begin
                nib    = sum_q[7:4];
                an_nxt = 2'b10;
                if (tc) state_nxt = DIG_ONES;
            end
            default: state_nxt = DIG_ONES;
        endcase
    end

    bcd_to_seg7 u_dec (
        .nibble     (nib),
        .force_dash (err_q),
        .pattern    (pattern)
    );

    // err looks at both nibbles so it stays steady across the scan
    always_comb begin
        seg_nxt = pattern;
        err_nxt = err_q | (sum_q[7:4] > BCD_MAX) | (sum_q[3:0] > BCD_MAX);
`ifdef BCD_DISP_LZ_BLANK_EN
        if (state == DIG_TENS && sum_q[7:4] == 4'd0 && !err_q) begin
            an_nxt  = 2'b00;
            seg_nxt = SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_BLANK ^ SEG_POL;
            an  <= 2'b00 ^ AN_POL;
            err <= 1'b0;
        end else begin
            seg <= seg_nxt ^ SEG_POL;
            an  <= an_nxt ^ AN_POL;
            err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_sum_display.sv
// Self-checking bench for bcd_sum_display: random and directed captures checked
// against a tick-count model of the scanned display.
module tb_bcd_sum_display;

    localparam int RD = 4;

    logic       clk, rst, sum_valid, in_err;
    logic [7:0] sum_in;
    logic [6:0] seg;
    logic [1:0] an;
    logic       err;

    int n_vec  = 0;
    int n_miss = 0;

    // model: ticks since reset release plus last captured value
    int         m_tick;
    logic [7:0] m_sum;
    logic       m_err;
    logic [6:0] exp_seg;
    logic [1:0] exp_an;
    logic       exp_err;
    logic [6:0] pat [10];

    bcd_sum_display #(.REFRESH_DIV(RD), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .sum_valid (sum_valid),
        .sum_in    (sum_in),
        .in_err    (in_err),
        .seg       (seg),
        .an        (an),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_out();
        int dig;
        logic [3:0] nb;
        dig = (m_tick / RD) % 2;
        nb  = (dig == 1) ? m_sum[7:4] : m_sum[3:0];
        exp_err = m_err || (m_sum[7:4] > 4'd9) || (m_sum[3:0] > 4'd9);
        if (m_err)          exp_seg = 7'b1000000;
        else if (nb > 4'd9) exp_seg = 7'b1111001;
        else                exp_seg = pat[nb];
        exp_an = (dig == 1) ? 2'b10 : 2'b01;
`ifdef BCD_DISP_LZ_BLANK_EN
        if (dig == 1 && m_sum[7:4] == 4'd0 && !m_err) begin
            exp_an  = 2'b00;
            exp_seg = 7'b0000000;
        end
`endif
    endfunction

    // one clock: drive inputs, predict outputs of this edge, advance model
    task automatic cyc(input logic v, input logic [7:0] s, input logic e);
        sum_valid = v;
        sum_in    = s;
        in_err    = e;
        model_out();
        @(posedge clk);
        #1;
        m_tick++;
        if (v) begin
            m_sum = s;
            m_err = e;
        end
    endtask

    function automatic logic [7:0] rand_sum();
        if ($urandom_range(0, 9) < 7)
            return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic model_reset();
        m_tick = 0;
        m_sum  = 8'h00;
        m_err  = 1'b0;
    endtask

    task automatic test_reset();
        if (seg !== 7'b0 || an !== 2'b00 || err !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_hold: seg=%b an=%b err=%b want 0000000 00 0", seg, an, err);
        end
        n_vec++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, rand_sum(), 1'($urandom_range(0, 1)));
            if (seg !== exp_seg || an !== exp_an || err !== exp_err) begin
                n_miss++;
                $display("FAIL reset_scan c%0d: seg=%b an=%b err=%b want seg=%b an=%b err=%b",
                         i, seg, an, err, exp_seg, exp_an, exp_err);
            end
            n_vec++;
        end
    endtask

    // single capture pulse, then hold with junk on sum_in
    task automatic test_capture(input string name, input logic [7:0] s, input logic e);
        cyc(1'b1, s, e);
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, rand_sum(), 1'($urandom_range(0, 1)));
            if (seg !== exp_seg || an !== exp_an || err !== exp_err) begin
                n_miss++;
                $display("FAIL %s c%0d: seg=%b an=%b err=%b want seg=%b an=%b err=%b",
                         name, i, seg, an, err, exp_seg, exp_an, exp_err);
            end
            n_vec++;
        end
    endtask

    task automatic test_tc_capture();
        for (int i = 0; i < 3 * RD && (m_tick % (2 * RD)) != RD - 1; i++) begin
            cyc(1'b0, 8'h00, 1'b0);
            if (seg !== exp_seg || an !== exp_an || err !== exp_err) begin
                n_miss++;
                $display("FAIL tc_align c%0d: seg=%b an=%b err=%b want seg=%b an=%b err=%b",
                         i, seg, an, err, exp_seg, exp_an, exp_err);
            end
            n_vec++;
        end
        cyc(1'b1, 8'h09, 1'b0);
        for (int i = 0; i < 2 * RD; i++) begin
            cyc(1'b0, 8'hFF, 1'b1);
            if (seg !== exp_seg || an !== exp_an || err !== exp_err) begin
                n_miss++;
                $display("FAIL tc_capture c%0d: seg=%b an=%b err=%b want seg=%b an=%b err=%b",
                         i, seg, an, err, exp_seg, exp_an, exp_err);
            end
            n_vec++;
        end
    endtask

    task automatic test_level_valid();
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, rand_sum(), ($urandom_range(0, 7) == 0));
            if (seg !== exp_seg || an !== exp_an || err !== exp_err) begin
                n_miss++;
                $display("FAIL level_valid c%0d: seg=%b an=%b err=%b want seg=%b an=%b err=%b",
                         i, seg, an, err, exp_seg, exp_an, exp_err);
            end
            n_vec++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 4) == 0), rand_sum(), ($urandom_range(0, 9) == 0));
            if (seg !== exp_seg || an !== exp_an || err !== exp_err) begin
                n_miss++;
                $display("FAIL random c%0d: seg=%b an=%b err=%b want seg=%b an=%b err=%b",
                         i, seg, an, err, exp_seg, exp_an, exp_err);
            end
            n_vec++;
        end
    endtask

    task automatic test_reset_mid_tens();
        cyc(1'b1, 8'h3C, 1'b0);
        for (int i = 0; i < 3 * RD && (m_tick % (2 * RD)) != RD + 2; i++)
            cyc(1'b0, 8'h00, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        if (seg !== 7'b0 || an !== 2'b00 || err !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_async: seg=%b an=%b err=%b want 0000000 00 0", seg, an, err);
        end
        n_vec++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 2 * RD + 2; i++) begin
            cyc(1'b0, 8'h77, 1'b1);
            if (seg !== exp_seg || an !== exp_an || err !== exp_err) begin
                n_miss++;
                $display("FAIL reset_restart c%0d: seg=%b an=%b err=%b want seg=%b an=%b err=%b",
                         i, seg, an, err, exp_seg, exp_an, exp_err);
            end
            n_vec++;
        end
    endtask

    initial begin
        pat[0] = 7'b0111111; pat[1] = 7'b0000110; pat[2] = 7'b1011011;
        pat[3] = 7'b1001111; pat[4] = 7'b1100110; pat[5] = 7'b1101101;
        pat[6] = 7'b1111101; pat[7] = 7'b0000111; pat[8] = 7'b1111111;
        pat[9] = 7'b1101111;
        rst       = 1'b1;
        sum_valid = 1'b0;
        sum_in    = 8'h00;
        in_err    = 1'b0;
        model_reset();
        #3;
        test_reset();
        test_capture("cap_17", 8'h17, 1'b0);
        test_capture("cap_3c", 8'h3C, 1'b0);
        test_capture("cap_inerr", 8'h05, 1'b1);
        test_capture("cap_c0", 8'hC0, 1'b0);
        test_tc_capture();
        test_level_valid();
        test_random();
        test_reset_mid_tens();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
